// File: rtl/trigger_in_cond_if.sv
// ============================================================================
// trigger_in_cond_if : trigger-conditioner register/strobe bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface trigger_in_cond_if #(
   parameter int CNT_W = 32
);
   logic             ext_trig_in;
   logic             reg_trig_en;
   logic [1:0]       reg_edge_sel;
   logic [15:0]      reg_filter_len;
   logic [31:0]      reg_holdoff;
   logic             reg_cnt_clr;
   logic             trig_level;
   logic             trig_pulse;
   logic             trig_busy;
   logic [CNT_W-1:0] trig_cnt;
   logic [CNT_W-1:0] drop_cnt;

   modport master (
      output ext_trig_in, reg_trig_en, reg_edge_sel, reg_filter_len,
             reg_holdoff, reg_cnt_clr,
      input  trig_level, trig_pulse, trig_busy, trig_cnt, drop_cnt
   );

   modport slave (
      input  ext_trig_in, reg_trig_en, reg_edge_sel, reg_filter_len,
             reg_holdoff, reg_cnt_clr,
      output trig_level, trig_pulse, trig_busy, trig_cnt, drop_cnt
   );
endinterface

`default_nettype wire

// File: rtl/trigger_in_cond.sv
// ============================================================================
// trigger_in_cond : sync, glitch-filter, edge-select and holdoff for ext trigger
// Rev 1.0
// ============================================================================
`default_nettype none

module trigger_in_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   trigger_in_cond_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [1:0]       SEL_RISE = 2'b00;
   localparam logic [1:0]       SEL_FALL = 2'b01;
   localparam logic [1:0]       SEL_BOTH = 2'b10;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [15:0]            flt_cnt;
   logic [15:0]            flt_len;
   logic [16:0]            flt_inc;
   logic                   flt_done;
   logic                   trig_level;
   logic                   trig_level_d;
   logic                   trig_pulse;
   logic                   trig_busy;
   logic                   rise;
   logic                   fall;
   logic                   match;
   logic                   accept;
   logic                   drop;
   logic [31:0]            hold_cnt;
   logic [31:0]            hold_nxt;
   logic [CNT_W-1:0]       trig_cnt;
   logic [CNT_W-1:0]       drop_cnt;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_comb begin
      flt_len  = (bus.reg_filter_len == 16'd0) ? 16'd1 : bus.reg_filter_len;
      flt_inc  = {1'b0, flt_cnt} + 17'd1;
      flt_done = (flt_inc >= {1'b0, flt_len});
      rise     = trig_level & ~trig_level_d;
      fall     = ~trig_level & trig_level_d;
      match    = ((bus.reg_edge_sel == SEL_RISE) & rise) |
                 ((bus.reg_edge_sel == SEL_FALL) & fall) |
                 ((bus.reg_edge_sel == SEL_BOTH) & (rise | fall));
      accept   = match & bus.reg_trig_en & (hold_cnt == 32'd0);
      drop     = match & bus.reg_trig_en & (hold_cnt != 32'd0);
      // Reload on accept wins over the running decrement
      if (accept) begin
         hold_nxt = bus.reg_holdoff;
      end else if (hold_cnt != 32'd0) begin
         hold_nxt = hold_cnt - 32'd1;
      end else begin
         hold_nxt = 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q       <= '0;
         flt_cnt      <= 16'd0;
         trig_level   <= 1'b0;
         trig_level_d <= 1'b0;
         trig_pulse   <= 1'b0;
         hold_cnt     <= 32'd0;
         trig_busy    <= 1'b0;
         trig_cnt     <= '0;
         drop_cnt     <= '0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.ext_trig_in};
         trig_level_d <= trig_level;

         if (sync_out == trig_level) begin
            flt_cnt <= 16'd0;
         end else if (flt_done) begin
            trig_level <= sync_out;
            flt_cnt    <= 16'd0;
         end else begin
            flt_cnt <= flt_inc[15:0];
         end

         trig_pulse <= accept;
         hold_cnt   <= hold_nxt;
         trig_busy  <= (hold_nxt != 32'd0);

         // Clear beats a same-cycle increment; counters stick at all-ones
         if (bus.reg_cnt_clr) begin
            trig_cnt <= '0;
         end else if (accept && (trig_cnt != CNT_MAX)) begin
            trig_cnt <= trig_cnt + CNT_ONE;
         end

         if (bus.reg_cnt_clr) begin
            drop_cnt <= '0;
         end else if (drop && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
         end
      end
   end

   assign bus.trig_level = trig_level;
   assign bus.trig_pulse = trig_pulse;
   assign bus.trig_busy  = trig_busy;
   assign bus.trig_cnt   = trig_cnt;
   assign bus.drop_cnt   = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trigger_in_cond.sv
// ============================================================================
// tb_trigger_in_cond : directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_trigger_in_cond;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   pulse_seen;
   int   level_seen;
   int   busy_seen;

   trigger_in_cond_if #(.CNT_W(32)) bus ();

   trigger_in_cond #(.SYNC_STAGES(2), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   always @(negedge clk) begin
      if (bus.trig_pulse === 1'b1) pulse_seen++;
      if (bus.trig_level === 1'b1) level_seen++;
      if (bus.trig_busy  === 1'b1) busy_seen++;
   end

   typedef struct {
      logic [1:0]  sel;
      logic        en;
      logic [15:0] flen;
      int          width;
      int          exp_pulses;
      int          exp_trig;
      int          exp_drop;
      int          exp_level;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      bus.reg_cnt_clr = 1'b1;
      @(negedge clk);
      bus.reg_cnt_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic latency(input int n);
      bus.reg_filter_len = 16'(n);
      bus.reg_edge_sel   = 2'b00;
      bus.reg_holdoff    = 32'd0;
      bus.ext_trig_in    = 1'b1;
      for (int k = 0; k <= n + 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("lat%0d_pulse_k%0d", n, k), bus.trig_pulse, (k == n + 2));
         check($sformatf("lat%0d_level_k%0d", n, k), bus.trig_level, (k >= n + 1));
      end
      @(negedge clk);
      bus.ext_trig_in = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int p0;
      int l0;
      bus.reg_edge_sel   = v.sel;
      bus.reg_trig_en    = v.en;
      bus.reg_filter_len = v.flen;
      bus.reg_holdoff    = 32'd0;
      clear_counts();
      p0 = pulse_seen;
      l0 = level_seen;
      bus.ext_trig_in = 1'b1;
      repeat (v.width) @(negedge clk);
      bus.ext_trig_in = 1'b0;
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d_pulses", idx), 64'(pulse_seen - p0), 64'(v.exp_pulses));
      check($sformatf("vec%0d_trig_cnt", idx), bus.trig_cnt, 64'(v.exp_trig));
      check($sformatf("vec%0d_drop_cnt", idx), bus.drop_cnt, 64'(v.exp_drop));
      check($sformatf("vec%0d_level_cycles", idx), 64'(level_seen - l0), 64'(v.exp_level));
   endtask

   initial begin
      int p0;
      int b0;
      checks     = 0;
      failures   = 0;
      pulse_seen = 0;
      level_seen = 0;
      busy_seen  = 0;

      //            sel    en    flen    w  pulses trig drop level
      vecs[0] = '{2'b00, 1'b1, 16'd4,  20, 1, 1, 0, 20};
      vecs[1] = '{2'b00, 1'b1, 16'd10,  9, 0, 0, 0,  0};
      vecs[2] = '{2'b00, 1'b1, 16'd10, 10, 1, 1, 0, 10};
      vecs[3] = '{2'b10, 1'b1, 16'd1,   5, 2, 2, 0,  5};
      vecs[4] = '{2'b11, 1'b1, 16'd1,   5, 0, 0, 0,  5};
      vecs[5] = '{2'b01, 1'b1, 16'd1,   5, 1, 1, 0,  5};
      vecs[6] = '{2'b10, 1'b0, 16'd1,   5, 0, 0, 0,  5};
      vecs[7] = '{2'b00, 1'b1, 16'd0,   1, 1, 1, 0,  1};

      rst                = 1'b0;
      bus.ext_trig_in    = 1'b0;
      bus.reg_trig_en    = 1'b1;
      bus.reg_edge_sel   = 2'b00;
      bus.reg_filter_len = 16'd1;
      bus.reg_holdoff    = 32'd0;
      bus.reg_cnt_clr    = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_level", bus.trig_level, 0);
      check("rst_pulse", bus.trig_pulse, 0);
      check("rst_busy",  bus.trig_busy,  0);
      check("rst_trig_cnt", bus.trig_cnt, 0);
      check("rst_drop_cnt", bus.drop_cnt, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      latency(1);
      latency(4);

      // Shrinking the filter length mid-count lets the level through on the next edge
      bus.reg_filter_len = 16'd20;
      bus.ext_trig_in    = 1'b1;
      repeat (10) @(negedge clk);
      check("flen_change_before", bus.trig_level, 0);
      bus.reg_filter_len = 16'd5;
      @(posedge clk);
      #1;
      check("flen_change_after", bus.trig_level, 1);
      @(negedge clk);
      bus.reg_filter_len = 16'd1;
      bus.ext_trig_in    = 1'b0;
      repeat (30) @(negedge clk);

      // Holdoff: six rising edges 2000 cycles apart, holdoff 3750
      bus.reg_holdoff = 32'd3750;
      clear_counts();
      p0 = pulse_seen;
      b0 = busy_seen;
      for (int e = 0; e < 6; e++) begin
         bus.ext_trig_in = 1'b1;
         repeat (100) @(negedge clk);
         bus.ext_trig_in = 1'b0;
         repeat (1900) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("hold_pulses", 64'(pulse_seen - p0), 3);
      check("hold_trig_cnt", bus.trig_cnt, 3);
      check("hold_drop_cnt", bus.drop_cnt, 3);
      check("hold_busy_cycles", 64'(busy_seen - b0), 3 * 3750);

      // Asynchronous reset during an active holdoff with the line held high
      bus.reg_holdoff = 32'd1000;
      bus.ext_trig_in = 1'b1;
      repeat (10) @(negedge clk);
      check("rmid_pre_busy", bus.trig_busy, 1);
      check("rmid_pre_trig_cnt", bus.trig_cnt, 4);
      rst = 1'b0;
      #1;
      check("rmid_level", bus.trig_level, 0);
      check("rmid_pulse", bus.trig_pulse, 0);
      check("rmid_busy",  bus.trig_busy,  0);
      check("rmid_trig_cnt", bus.trig_cnt, 0);
      check("rmid_drop_cnt", bus.drop_cnt, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rmid_post_pulse_k%0d", k), bus.trig_pulse, (k == 3));
      end
      check("rmid_post_trig_cnt", bus.trig_cnt, 1);
      @(negedge clk);
      bus.ext_trig_in = 1'b0;
      bus.reg_holdoff = 32'd0;
      repeat (1100) @(negedge clk);

      // Counter clear coinciding with an accept
      bus.ext_trig_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.reg_cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      check("clr_accept_pulse", bus.trig_pulse, 1);
      check("clr_accept_trig_cnt", bus.trig_cnt, 0);
      @(negedge clk);
      bus.reg_cnt_clr = 1'b0;
      repeat (5) @(negedge clk);
      check("clr_accept_hold0", bus.trig_cnt, 0);
      bus.ext_trig_in = 1'b0;
      repeat (20) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/trigger_in_cond.md
Name: trigger_in_cond

Overview:
- Input conditioner directly upstream of trigger_delay_ctrl.
- Takes the raw asynchronous external trigger (photo-sensor / encoder line) and synchronises it, glitch-filters it and selects the active edge.
- Enforces a minimum re-trigger interval and delivers a clean level plus a one-cycle pulse; the clean level feeds trigger_delay_ctrl.trigger_in.
- Keeps accepted/dropped trigger counters for register readback.

Parameters:
SYNC_STAGES, 2, synchroniser depth on ext_trig_in (legal 2..4)
CNT_W, 32, width of trig_cnt and drop_cnt

Ports:
clk  input  1  system clock (125 MHz, 8 ns)
rst  input  1  asynchronous, active-low reset
ext_trig_in  input  1  raw external trigger, asynchronous to clk
reg_trig_en  input  1  1 = accept triggers; 0 = ignore edges (level path still runs)
reg_edge_sel  input  2  00 rising, 01 falling, 10 both, 11 none
reg_filter_len  input  16  consecutive cycles a new level must persist; 0 treated as 1
reg_holdoff  input  32  minimum cycles after an accepted trigger before the next is accepted; 0 = no holdoff
reg_cnt_clr  input  1  synchronous clear of trig_cnt and drop_cnt
trig_level  output  1  filtered level, to trigger_delay_ctrl.trigger_in
trig_pulse  output  1  one-cycle pulse per accepted edge
trig_busy  output  1  high while the holdoff counter is non-zero
trig_cnt  output  CNT_W  accepted trigger count
drop_cnt  output  CNT_W  edges rejected by holdoff

Behaviour:
- **Reset** (rst low, asynchronous): all synchroniser flops, filter counter, trig_level, trig_pulse, holdoff counter, trig_busy, trig_cnt and drop_cnt go to 0. Release is synchronous to clk through the normal flop path.
- **Synchroniser:** SYNC_STAGES flops; sync_out is the last stage.
- **Glitch filter:**
  - Uses a 16-bit flt_cnt. On each clk edge where sync_out != trig_level, flt_cnt increments.
  - When flt_cnt+1 >= max(reg_filter_len,1): trig_level <= sync_out and flt_cnt <= 0.
  - On any edge where sync_out == trig_level, flt_cnt <= 0. A pulse shorter than reg_filter_len cycles therefore never reaches trig_level.
- **Edge detect:**
  - trig_level_d is trig_level registered. rise = trig_level & ~trig_level_d; fall = ~trig_level & trig_level_d.
  - match = (sel==00 & rise) | (sel==01 & fall) | (sel==10 & (rise|fall)); sel==11 never matches.
- **Accept/drop decision** (registered, evaluated on the cycle match is true):
  - match & reg_trig_en & hold_cnt==0 → accept:
    - trig_pulse=1 for exactly one cycle;
    - trig_cnt+1;
    - hold_cnt <= reg_holdoff.
  - match & reg_trig_en & hold_cnt!=0 → drop:
    - drop_cnt+1;
    - no pulse;
    - hold_cnt unchanged (it is not restarted).
  - match & !reg_trig_en → ignored; no count of any kind.
- **Holdoff counter:**
  - hold_cnt decrements by 1 each cycle while non-zero. Decrement has lower priority than reload on accept.
  - trig_busy = (hold_cnt != 0), registered.
  - Changing reg_holdoff mid-count does not affect the running count.
- **Latency:** let E0 be the first clk edge that samples the new ext_trig_in level and N = max(reg_filter_len,1).
  - trig_level changes at E0+SYNC_STAGES+N-1.
  - trig_pulse is high during the cycle after edge E0+SYNC_STAGES+N.
  - With defaults and N=1: pulse is high 3 cycles after E0.
- **Counters:**
  - Saturate at all-ones.
  - reg_cnt_clr has priority over a same-cycle increment; the result is 0.
- **reg_filter_len change while filtering:** takes effect on the next compare. If flt_cnt already meets or exceeds the new length, trig_level updates on that edge.
- **reg_edge_sel change:** takes effect on the next cycle.
- **Reset mid-holdoff or mid-filter:** everything clears. After reset, trig_level=0, so an external line held high produces one rising edge once filtered.

Test Plan:
1. **Clean edges:** defaults, reg_filter_len=4, reg_holdoff=0, edge=rising; ext_trig_in square wave of period 4152 cycles → one trig_pulse per period, 2+4 cycles after E0; trig_cnt=8 after 8 periods; drop_cnt=0.
2. **Glitch rejection:** reg_filter_len=10; 9-cycle high glitch, then a 10-cycle high pulse → first produces no trig_level change; second gives trig_level high for the filtered width and trig_cnt=1.
3. **Holdoff:** reg_holdoff=3750, rising edges every 2000 cycles, 6 edges → accepted edges 1,3,5; drop_cnt=3; trig_busy high for 3750 cycles after each accept.
4. **Edge select:** reg_edge_sel=10, one full high/low pulse → 2 pulses. reg_edge_sel=11 → 0 pulses and no counts. reg_edge_sel=01 → pulse only on the falling edge.
5. **Enable and clear:** reg_trig_en=0 during 3 edges → trig_cnt and drop_cnt unchanged. Assert reg_cnt_clr in the same cycle as an accept → trig_cnt=0, trig_pulse still asserted.
6. **Reset mid-operation:** rst low during an active holdoff with ext_trig_in high → all outputs 0 immediately. After release, a rising trig_pulse is seen N+2 cycles later and trig_cnt=1.
